system_cnt_sequencer: RTL

SYSTEM_CNT_SEQUENCER -- requirements
Module: system_cnt_sequencer

---
 rtl/system_cnt_seq_pkg.sv | 24 ++
 rtl/system_cnt_sequencer_if.sv | 21 ++
 rtl/system_cnt_seq_sync.sv | 42 ++++
 rtl/system_cnt_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/system_cnt_seq_pkg.sv
// Shared constants for the counted pulse sequencer: register addresses,
// CTRL/STATUS bit positions and the sequencer state encoding.
package system_cnt_seq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_ABORT_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_EXT_TRIG_BIT = 3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/system_cnt_sequencer_if.sv
// Avalon-MM register port of the sequencer: combinational read, zero wait
// states, active-low write strobe.
interface system_cnt_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/system_cnt_seq_sync.sv
// Brings the asynchronous trigger into clk and emits a one-cycle registered
// pulse on each rising edge, SYNC stages + 1 cycles after first sampling.
module system_cnt_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              rise_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_i;
      end else begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/system_cnt_sequencer.sv
// Counted pulse sequencer: emits COUNT one-cycle ticks spaced PERIOD+1 clocks
// apart after a register or external-trigger start, with done/irq reporting.
module system_cnt_sequencer
  import system_cnt_seq_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  system_cnt_sequencer_if.slave   avs,
  input  logic                    trig_in,
  output logic                    pulse_out,
  output logic                    busy,
  output logic                    irq,
  output logic [31:0]             remaining
);

  state_e               state_q;
  logic [31:0]          count_q;
  logic [PERIOD_W-1:0]  period_q;
  logic [PERIOD_W-1:0]  period_run_q;
  logic [PERIOD_W-1:0]  timer_q;
  logic [31:0]          remaining_q;
  logic                 irq_en_q;
  logic                 ext_trig_en_q;
  logic                 done_q;

  logic wr_en;
  logic ctrl_wr;
  logic abort_cmd;
  logic start_cmd;
  logic trig_rise;
  logic start_evt;
  logic timer_zero;

  system_cnt_seq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (trig_in),
    .rise_o  (trig_rise)
  );

  assign wr_en      = avs.chipselect & ~avs.write_n;
  assign ctrl_wr    = wr_en && (avs.address == ADDR_CTRL);
  assign abort_cmd  = ctrl_wr & avs.writedata[CTRL_ABORT_BIT];
  assign start_cmd  = ctrl_wr & avs.writedata[CTRL_START_BIT];
  // Abort outranks any start arriving in the same cycle, register or trigger.
  assign start_evt  = (start_cmd | (trig_rise & ext_trig_en_q)) & ~abort_cmd;
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      period_q      <= '0;
      period_run_q  <= '0;
      timer_q       <= '0;
      remaining_q   <= '0;
      irq_en_q      <= 1'b0;
      ext_trig_en_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (wr_en && (avs.address == ADDR_COUNT))
        count_q <= avs.writedata;
      if (wr_en && (avs.address == ADDR_PERIOD))
        period_q <= avs.writedata[PERIOD_W-1:0];
      if (ctrl_wr) begin
        irq_en_q      <= avs.writedata[CTRL_IRQ_EN_BIT];
        ext_trig_en_q <= avs.writedata[CTRL_EXT_TRIG_BIT];
      end
      // The W1C clear sits before the FSM so a coincident done-set overrides it.
      if (wr_en && (avs.address == ADDR_STATUS) && avs.writedata[STATUS_DONE_BIT])
        done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_evt) begin
            remaining_q  <= count_q;
            timer_q      <= period_q;
            period_run_q <= period_q;
            if (count_q != 32'd0) begin
              done_q  <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_RUN: begin
          if (abort_cmd) begin
            state_q <= ST_IDLE;
          end else if (!timer_zero) begin
            timer_q <= timer_q - PERIOD_W'(1);
          end else begin
            timer_q <= period_run_q;
            if (remaining_q != 32'd0)
              remaining_q <= remaining_q - 32'd1;
            if (remaining_q < 32'd2) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pulse_out = (state_q == ST_RUN) && timer_zero && !abort_cmd;
  assign busy      = (state_q != ST_IDLE);
  assign irq       = done_q & irq_en_q;
  assign remaining = remaining_q;

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_CTRL: begin
        avs.readdata[CTRL_IRQ_EN_BIT]   = irq_en_q;
        avs.readdata[CTRL_EXT_TRIG_BIT] = ext_trig_en_q;
      end
      ADDR_COUNT:  avs.readdata = count_q;
      ADDR_PERIOD: avs.readdata = 32'(period_q);
      ADDR_STATUS: begin
        avs.readdata[STATUS_DONE_BIT] = done_q;
        avs.readdata[STATUS_BUSY_BIT] = busy;
      end
      default: avs.readdata = '0;
    endcase
  end

endmodule
